// File: rtl/sha_mem_responder_if.sv
// Read request/response channel between the SHA chunk fetcher and its message store.
// No ready signal: the requester strobes an address, the responder answers a fixed latency later.
interface sha_mem_responder_if;
  logic        mem_addr_vld;
  logic [31:0] mem_addr;
  logic        mem_data_vld;
  logic [31:0] mem_data;

  modport master (output mem_addr_vld, output mem_addr, input mem_data_vld, input mem_data);
  modport slave  (input mem_addr_vld, input mem_addr, output mem_data_vld, output mem_data);
endinterface

// File: rtl/sha_mem_responder.sv
// Message-word store answering SHA chunk fetch reads in order after LATENCY cycles.
// A host write port loads the RAM; sticky flags record out-of-range and misaligned requests.
module sha_mem_responder #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned AW      = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  sha_mem_responder_if.slave   mem,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [31:0]          wr_data,
  output logic [2:0]           outstanding,
  output logic                 err_oor,
  output logic                 err_misalign,
  output logic [15:0]          req_count
);

  localparam int unsigned DW  = 32;
  localparam int unsigned CW  = 3;
  localparam int unsigned RCW = 16;

  logic [DW-1:0]      ram [DEPTH];
  logic               req;
  logic               rsp;
  logic [AW-1:0]      rd_idx;
  logic               rd_oor;
  logic               rd_mis;
  logic [DW-1:0]      rd_data;
  logic [LATENCY-1:0] pipe_vld;
  logic [DW-1:0]      pipe_data [LATENCY];

  assign req    = mem.mem_addr_vld;
  assign rsp    = pipe_vld[LATENCY-1];
  assign rd_idx = mem.mem_addr[AW+1:2];
  assign rd_oor = |mem.mem_addr[DW-1:AW+2];
  assign rd_mis = |mem.mem_addr[1:0];

  // Read word: a same-cycle write to the same word wins; out-of-range reads return zero.
  always_comb begin
    rd_data = ram[rd_idx];
    if (wr_en && (wr_addr == rd_idx)) rd_data = wr_data;
    if (rd_oor) rd_data = '0;
  end

  // RAM contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en) ram[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_vld[0]  <= 1'b0;
      pipe_data[0] <= '0;
    end else begin
      pipe_vld[0] <= req;
      if (req) pipe_data[0] <= rd_data;
    end
  end

  // Data only advances with a valid beat so the last stage holds the previous response.
  for (genvar k = 1; k < LATENCY; k++) begin : g_stage
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        pipe_vld[k]  <= 1'b0;
        pipe_data[k] <= '0;
      end else begin
        pipe_vld[k] <= pipe_vld[k-1];
        if (pipe_vld[k-1]) pipe_data[k] <= pipe_data[k-1];
      end
    end
  end

  assign mem.mem_data_vld = pipe_vld[LATENCY-1];
  assign mem.mem_data     = pipe_data[LATENCY-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outstanding  <= '0;
      req_count    <= '0;
      err_oor      <= 1'b0;
      err_misalign <= 1'b0;
    end else begin
      if (req && !rsp && (outstanding < CW'(LATENCY))) begin
        outstanding <= outstanding + CW'(1);
      end else if (!req && rsp && (outstanding != '0)) begin
        outstanding <= outstanding - CW'(1);
      end
      if (req) req_count <= req_count + RCW'(1);
      if (req && rd_oor) err_oor <= 1'b1;
      if (req && rd_mis) err_misalign <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sha_mem_responder.sv
// Bench for sha_mem_responder: three instances (LATENCY 1, 2, 4) share one stimulus stream
// and are compared every cycle against a timeline model of expected responses.
module tb_sha_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_v;
  logic [31:0] req_a;
  logic        we;
  logic [7:0]  wa;
  logic [31:0] wd;

  always #5 clk = ~clk;

  sha_mem_responder_if bus0 ();
  sha_mem_responder_if bus1 ();
  sha_mem_responder_if bus2 ();

  assign bus0.mem_addr_vld = req_v;
  assign bus0.mem_addr     = req_a;
  assign bus1.mem_addr_vld = req_v;
  assign bus1.mem_addr     = req_a;
  assign bus2.mem_addr_vld = req_v;
  assign bus2.mem_addr     = req_a;

  logic        o_vld [3];
  logic [31:0] o_data [3];
  logic [2:0]  outst [3];
  logic        eo [3];
  logic        em [3];
  logic [15:0] rc [3];

  assign o_vld[0]  = bus0.mem_data_vld;
  assign o_data[0] = bus0.mem_data;
  assign o_vld[1]  = bus1.mem_data_vld;
  assign o_data[1] = bus1.mem_data;
  assign o_vld[2]  = bus2.mem_data_vld;
  assign o_data[2] = bus2.mem_data;

  sha_mem_responder #(.DEPTH(256), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .mem(bus0), .wr_en(we), .wr_addr(wa), .wr_data(wd),
    .outstanding(outst[0]), .err_oor(eo[0]), .err_misalign(em[0]), .req_count(rc[0]));
  sha_mem_responder #(.DEPTH(256), .LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst), .mem(bus1), .wr_en(we), .wr_addr(wa), .wr_data(wd),
    .outstanding(outst[1]), .err_oor(eo[1]), .err_misalign(em[1]), .req_count(rc[1]));
  sha_mem_responder #(.DEPTH(256), .LATENCY(4)) u_l4 (
    .clk(clk), .rst(rst), .mem(bus2), .wr_en(we), .wr_addr(wa), .wr_data(wd),
    .outstanding(outst[2]), .err_oor(eo[2]), .err_misalign(em[2]), .req_count(rc[2]));

  // Reference model: word store plus a per-instance calendar of due responses.
  int          lat [3] = '{1, 2, 4};
  logic [31:0] mram [256];
  logic        sv [3][64];
  logic [31:0] sd [3][64];
  int          pend [3];
  int          peak [3];
  logic [31:0] last [3];
  logic [15:0] mrc;
  logic        meo;
  logic        mem_mis;
  int          cyc;
  int          checks;
  int          failures;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int d = 0; d < 3; d++) begin
      for (int s = 0; s < 64; s++) sv[d][s] = 1'b0;
      pend[d] = 0;
      last[d] = '0;
    end
    mrc     = '0;
    meo     = 1'b0;
    mem_mis = 1'b0;
  endtask

  task automatic observe();
    for (int d = 0; d < 3; d++) begin
      int   slot;
      logic ev;
      slot = cyc % 64;
      ev   = sv[d][slot];
      if (ev) last[d] = sd[d][slot];
      if (32'(outst[d]) > 32'(peak[d])) peak[d] = int'(outst[d]);
      chk($sformatf("L%0d_vld", lat[d]), 32'(o_vld[d]), 32'(ev));
      chk($sformatf("L%0d_data", lat[d]), o_data[d], last[d]);
      chk($sformatf("L%0d_outstanding", lat[d]), 32'(outst[d]), 32'(pend[d]));
      chk($sformatf("L%0d_req_count", lat[d]), 32'(rc[d]), 32'(mrc));
      chk($sformatf("L%0d_err_oor", lat[d]), 32'(eo[d]), 32'(meo));
      chk($sformatf("L%0d_err_misalign", lat[d]), 32'(em[d]), 32'(mem_mis));
      if (ev) begin
        pend[d]--;
        sv[d][slot] = 1'b0;
      end
    end
  endtask

  // One cycle: check what the DUTs show now, then apply this cycle's inputs.
  task automatic step(input logic v, input logic [31:0] a, input logic w,
                      input logic [7:0] wadr, input logic [31:0] wdat);
    logic [7:0]  idx;
    logic [31:0] data;
    logic [21:0] hi;
    observe();
    if (v) begin
      idx  = a[9:2];
      hi   = a[31:10];
      data = (hi != '0) ? 32'h0 : ((w && wadr == idx) ? wdat : mram[idx]);
      for (int d = 0; d < 3; d++) begin
        sv[d][(cyc + lat[d]) % 64] = 1'b1;
        sd[d][(cyc + lat[d]) % 64] = data;
        pend[d]++;
      end
      mrc++;
      if (hi != '0) meo = 1'b1;
      if (a[1:0] != 2'b00) mem_mis = 1'b1;
    end
    if (w) mram[wadr] = wdat;
    req_v = v;
    req_a = a;
    we    = w;
    wa    = wadr;
    wd    = wdat;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 8'h0, 32'h0);
  endtask

  initial begin
    logic [31:0] a;
    logic [7:0]  ix;
    int          r;
    checks   = 0;
    failures = 0;
    cyc      = 0;
    for (int d = 0; d < 3; d++) peak[d] = 0;
    model_clear();
    req_v = 1'b0;
    req_a = '0;
    we    = 1'b0;
    wa    = '0;
    wd    = '0;

    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    observe();
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    cyc++;

    // Load: words 0..15 hold a recognisable pattern, the rest random.
    for (int i = 0; i < 256; i++)
      step(1'b0, 32'h0, 1'b1, 8'(i), (i < 16) ? 32'h1000_0000 + 32'(i) : $urandom);
    idle(4);

    step(1'b1, 32'h0000_0008, 1'b0, 8'h0, 32'h0);
    idle(6);

    for (int d = 0; d < 3; d++) peak[d] = 0;
    for (int i = 0; i < 16; i++) step(1'b1, 32'(i * 4), 1'b0, 8'h0, 32'h0);
    idle(6);
    for (int d = 0; d < 3; d++)
      chk($sformatf("L%0d_outstanding_peak", lat[d]), 32'(peak[d]), 32'(lat[d]));

    // Read one cycle before a write to the same word, then in the same cycle as a write.
    step(1'b1, 32'h0000_0014, 1'b0, 8'h0, 32'h0);
    step(1'b1, 32'h0000_0014, 1'b1, 8'd5, 32'hDEAD_BEEF);
    idle(6);

    step(1'b1, 32'h0000_0400, 1'b0, 8'h0, 32'h0);
    step(1'b1, 32'h0000_0006, 1'b0, 8'h0, 32'h0);
    idle(8);

    // Reset with requests in flight.
    step(1'b1, 32'h0000_0008, 1'b0, 8'h0, 32'h0);
    step(1'b1, 32'h0000_000C, 1'b0, 8'h0, 32'h0);
    req_v = 1'b0;
    rst   = 1'b0;
    #1;
    model_clear();
    observe();
    repeat (2) @(posedge clk);
    #1;
    observe();
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    cyc += 3;
    idle(6);
    step(1'b1, 32'h0000_0008, 1'b0, 8'h0, 32'h0);
    idle(6);

    // Random mixed traffic with host writes.
    for (int i = 0; i < 1500; i++) begin
      ix = 8'($urandom);
      r  = int'($urandom_range(0, 9));
      a  = {22'd0, ix, 2'b00};
      if (r == 7) a[1:0] = 2'($urandom_range(1, 3));
      if (r >= 8) a[31:10] = 22'($urandom_range(1, 32'h3F_FFFF));
      if (r == 9) a[1:0] = 2'($urandom_range(1, 3));
      step(($urandom % 4) != 0, a, ($urandom % 3) == 0, 8'($urandom), $urandom);
    end
    idle(6);

    // Enough back-to-back requests to carry req_count through its wrap.
    for (int i = 0; i < 65540; i++)
      step(1'b1, {22'd0, 8'($urandom), 2'b00}, 1'b0, 8'h0, 32'h0);
    idle(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
